// File: rtl/bias_act_stage_pkg.sv
// Shared fixed-point defaults, activation encodings and FSM state type for bias_act_stage.
package bias_act_stage_pkg;
  localparam int QN_DEF       = 6;
  localparam int QM_DEF       = 11;
  localparam int BITWIDTH_DEF = QN_DEF + QM_DEF + 1;

  localparam logic ACT_SIGMOID = 1'b0;
  localparam logic ACT_TANH    = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} stateT;
endpackage

// File: rtl/bias_act_stage_pwl.sv
// pwl_act: combinational hard sigmoid / hard tanh on one signed fixed-point element.
module pwl_act
  import bias_act_stage_pkg::*;
#(
  parameter int QM       = QM_DEF,
  parameter int BITWIDTH = BITWIDTH_DEF
) (
  input  logic signed [BITWIDTH-1:0] s,
  input  logic                       actSel,
  output logic signed [BITWIDTH-1:0] y
);
  localparam logic signed [BITWIDTH-1:0] ONE = BITWIDTH'(1 << QM);

  logic signed [BITWIDTH-1:0] sig;

  always_comb begin
    // |s>>>2| <= 2^(BITWIDTH-3), so adding ONE/2 cannot overflow
    sig = (s >>> 2) + (ONE >>> 1);
    y   = s;
    if (actSel == ACT_TANH) begin
      if (s > ONE)       y = ONE;
      else if (s < -ONE) y = -ONE;
      else               y = s;
    end else begin
      if (sig < 0)        y = '0;
      else if (sig > ONE) y = ONE;
      else                y = sig;
    end
  end
endmodule

// File: rtl/bias_act_stage.sv
// Bias add + piecewise-linear activation over a captured dot_prod vector, one element per cycle.
// Optional BIAS_SAT_COUNT_EN adds satCount, counting saturated bias adds.
module bias_act_stage
  import bias_act_stage_pkg::*;
#(
  parameter int NROW              = 32,
  parameter int QN                = QN_DEF,
  parameter int QM                = QM_DEF,
  parameter int BITWIDTH          = QN + QM + 1,
  parameter int ROW_ADDR_BITWIDTH = $clog2(NROW)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         dataReady,
  input  logic [NROW*BITWIDTH-1:0]     inVec,
  input  logic                         actSel,
  input  logic                         biasWriteEn,
  input  logic [ROW_ADDR_BITWIDTH-1:0] biasAddr,
  input  logic [BITWIDTH-1:0]          biasIn,
  output logic [NROW*BITWIDTH-1:0]     actVec,
  output logic                         actReady,
  output logic                         busy,
  output logic                         overrun
`ifdef BIAS_SAT_COUNT_EN
  ,
  output logic [15:0]                  satCount
`endif
);
  localparam logic [BITWIDTH-1:0] MAXV = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0] MINV = {1'b1, {(BITWIDTH-1){1'b0}}};

  stateT state, stateNext;
  logic dataReadyQ, edgeDet, issue, done, capSel, sumSat;
  logic [NROW-1:0][BITWIDTH-1:0] capVec, biasReg;
  logic [ROW_ADDR_BITWIDTH-1:0] elemIdx, s1Idx;
  logic [BITWIDTH:0] sumWide;
  logic signed [BITWIDTH-1:0] sumClamp, s1Sum, actOut;
  logic [1:0] vldPipe;

  assign edgeDet = dataReady & ~dataReadyQ;

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (edgeDet) stateNext = RUN;
      RUN: begin
        issue = 1'b1;
        if (elemIdx == ROW_ADDR_BITWIDTH'(NROW - 1)) stateNext = FLUSH;
      end
      FLUSH: begin
        // last element has been written into actVec
        if (vldPipe[1] && !vldPipe[0]) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    sumWide  = {capVec[elemIdx][BITWIDTH-1], capVec[elemIdx]} +
               {biasReg[elemIdx][BITWIDTH-1], biasReg[elemIdx]};
    sumSat   = sumWide[BITWIDTH] ^ sumWide[BITWIDTH-1];
    sumClamp = sumSat ? (sumWide[BITWIDTH] ? MINV : MAXV) : sumWide[BITWIDTH-1:0];
  end

  pwl_act #(.QM(QM), .BITWIDTH(BITWIDTH)) uAct (
    .s      (s1Sum),
    .actSel (capSel),
    .y      (actOut)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dataReadyQ <= 1'b0;
      capVec     <= '0;
      biasReg    <= '0;
      capSel     <= 1'b0;
      elemIdx    <= '0;
      s1Idx      <= '0;
      s1Sum      <= '0;
      vldPipe    <= '0;
      actVec     <= '0;
      actReady   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= stateNext;
      dataReadyQ <= dataReady;
      actReady   <= done;
      overrun    <= edgeDet && (state != IDLE);
      vldPipe    <= {vldPipe[0], issue};
      if (state == IDLE && edgeDet) begin
        capVec  <= inVec;
        capSel  <= actSel;
        elemIdx <= '0;
        busy    <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (biasWriteEn && state == IDLE && !edgeDet && (32'(biasAddr) < NROW))
        biasReg[biasAddr] <= biasIn;
      if (issue) begin
        elemIdx <= elemIdx + 1'b1;
        s1Idx   <= elemIdx;
        s1Sum   <= sumClamp;
      end
      if (vldPipe[0]) actVec[s1Idx*BITWIDTH +: BITWIDTH] <= actOut;
    end
  end

`ifdef BIAS_SAT_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) satCount <= '0;
    else if (issue && sumSat && satCount != 16'hFFFF) satCount <= satCount + 16'd1;
  end
`endif
endmodule
